// File: rtl/banco_salida_rtc_pkg.sv
// banco_salida_rtc shared types and constants.
// State encoding, default command index, status bit map.
package banco_salida_rtc_pkg;

  localparam int NPORT       = 8;
  localparam int NSNAP       = 7;
  localparam int CMD_IDX_DEF = 7;

  localparam int ST_BUSY     = 0;
  localparam int ST_OVERRUN  = 1;
  localparam int ST_TIMEOUT  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

endpackage

// File: rtl/banco_salida_rtc_if.sv
// PicoBlaze output side plus RTC req/ack side of banco_salida_rtc.
// slave = register bank, master = driver/observer.
interface banco_salida_rtc_if #(
  parameter int DATA_W = 8
);

  logic [7:0]          enable;
  logic                write_strobe;
  logic [DATA_W-1:0]   out_port;
  logic                ack;
  logic [8*DATA_W-1:0] port_q;
  logic [7*DATA_W-1:0] snap_q;
  logic [DATA_W-1:0]   cmd_q;
  logic                req;
  logic                busy;
  logic                done;
  logic [7:0]          status;

  modport slave (
    input  enable, write_strobe, out_port, ack,
    output port_q, snap_q, cmd_q,
    output req, busy, done, status
  );

  modport master (
    output enable, write_strobe, out_port, ack,
    input  port_q, snap_q, cmd_q,
    input  req, busy, done, status
  );

endinterface

// File: rtl/banco_salida_rtc_hs_timeout_cnt.sv
// Clearable saturating handshake counter.
// hit_o flags the increment that lands on MAX.
module hs_timeout_cnt #(
  parameter int MAX = 1023,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] PRE_V = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != MAX_V) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign hit_o = inc_i && (cnt_q == PRE_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/banco_salida_rtc.sv
// PicoBlaze output register bank with commit engine
// driving a four-phase req/ack handshake to the RTC bus.
module banco_salida_rtc
  import banco_salida_rtc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CMD_IDX = CMD_IDX_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst,
  banco_salida_rtc_if.slave bus
);

  typedef logic [DATA_W-1:0] byte_t;

  logic                   ws_q;
  logic [NPORT-1:0]       wr;
  byte_t [NPORT-1:0]      port_q, port_d;
  byte_t [NSNAP-1:0]      snap_q, snap_d;
  byte_t                  cmd_q, cmd_d;
  state_e                 state_q, state_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;
  logic                   tmo_q, tmo_d;
  logic                   commit, can_go, go;
  logic                   hit;
  logic                   busy;
  logic [7:0]             status;

  // enable lags write_strobe by a cycle; realign here
  assign wr = {NPORT{ws_q}} & bus.enable;

  always_comb begin
    port_d = port_q;
    for (int i = 0; i < NPORT; i++) begin
      if (wr[i]) port_d[i] = bus.out_port;
    end
  end

  assign commit = wr[CMD_IDX];
  assign can_go = (state_q == IDLE) ||
                  (state_q == WAIT_LOW && !bus.ack);
  assign go     = commit && can_go;

  hs_timeout_cnt #(
    .MAX (TIMEOUT)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i ((state_q != REQ) || bus.ack),
    .inc_i (state_q == REQ),
    .hit_o (hit)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    tmo_d   = tmo_q;
    snap_d  = snap_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: ;
      REQ: begin
        if (bus.ack) begin
          state_d = WAIT_LOW;
        end else if (hit) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!bus.ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // snapshot includes any same-cycle port write
    if (go) begin
      state_d = REQ;
      snap_d  = port_d[NSNAP-1:0];
      cmd_d   = bus.out_port;
      ovr_d   = 1'b0;
      tmo_d   = 1'b0;
    end else if (commit) begin
      ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_q    <= 1'b0;
      port_q  <= '0;
      snap_q  <= '0;
      cmd_q   <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      ws_q    <= bus.write_strobe;
      port_q  <= port_d;
      snap_q  <= snap_d;
      cmd_q   <= cmd_d;
      state_q <= state_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    status             = '0;
    status[ST_BUSY]    = busy;
    status[ST_OVERRUN] = ovr_q;
    status[ST_TIMEOUT] = tmo_q;
  end

  assign bus.port_q = port_q;
  assign bus.snap_q = snap_q;
  assign bus.cmd_q  = cmd_q;
  assign bus.req    = (state_q == REQ);
  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.status = status;

endmodule

// File: tb/tb_banco_salida_rtc.sv
// Self-checking bench for banco_salida_rtc.
// Vector table for port writes, scripted handshake sequences.
module tb_banco_salida_rtc;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  banco_salida_rtc_if #(.DATA_W(8)) bus ();

  banco_salida_rtc #(
    .DATA_W  (8),
    .CMD_IDX (7),
    .TIMEOUT (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        ws;
    logic [7:0]  en;
    logic [7:0]  d;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [55:0] snap;
    logic [7:0]  cmd;
  } com_t;

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  logic req_prev = 1'b0;
  com_t exp_q[$];

  localparam logic [55:0] SNAP_A = 56'h16151413121110;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr_port(input int idx, input logic [7:0] d);
    bus.write_strobe = 1'b1;
    bus.out_port     = d;
    bus.enable       = 8'h00;
    step();
    bus.write_strobe = 1'b0;
    bus.enable       = 8'(1 << idx);
    step();
    bus.enable       = 8'h00;
  endtask

  task automatic push(input logic [55:0] s, input logic [7:0] c);
    com_t e;
    e.snap = s;
    e.cmd  = c;
    exp_q.push_back(e);
  endtask

  // scoreboard: each req rise must match the oldest commit
  always @(negedge clk) begin
    com_t e;
    if (bus.req && !req_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL commit_unexpected act_cmd=%h exp=none",
                 bus.cmd_q);
      end else begin
        e = exp_q.pop_front();
        check("commit_cmd", 64'(bus.cmd_q), 64'(e.cmd));
        check("commit_snap", 64'(bus.snap_q), 64'(e.snap));
      end
    end
    if (bus.done) done_cnt++;
    req_prev = bus.req;
  end

  initial begin
    vec_t        tbl[7];
    logic [63:0] prev;
    int          n;
    int          dc;

    tbl[0] = '{1'b1, 8'h04, 8'hA5, 64'h0000_0000_00A5_0000};
    tbl[1] = '{1'b1, 8'h01, 8'h11, 64'h0000_0000_00A5_0011};
    tbl[2] = '{1'b1, 8'h42, 8'h5A, 64'h005A_0000_00A5_5A11};
    tbl[3] = '{1'b1, 8'h20, 8'hFF, 64'h005A_FF00_00A5_5A11};
    tbl[4] = '{1'b1, 8'h00, 8'h77, 64'h005A_FF00_00A5_5A11};
    tbl[5] = '{1'b0, 8'h01, 8'h99, 64'h005A_FF00_00A5_5A11};
    tbl[6] = '{1'b1, 8'h04, 8'h3C, 64'h005A_FF00_003C_5A11};

    bus.enable       = 8'h00;
    bus.write_strobe = 1'b0;
    bus.out_port     = 8'h00;
    bus.ack          = 1'b0;

    #3;
    check("rst_port", bus.port_q, 64'h0);
    check("rst_req", 64'(bus.req), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_status", 64'(bus.status), 64'h0);
    check("rst_cmd", 64'(bus.cmd_q), 64'h0);
    step();
    step();
    rst = 1'b1;
    step();

    prev = 64'h0;
    for (int i = 0; i < 7; i++) begin
      bus.write_strobe = tbl[i].ws;
      bus.out_port     = tbl[i].d;
      bus.enable       = 8'h00;
      step();
      check($sformatf("wr%0d_early", i), bus.port_q, prev);
      bus.write_strobe = 1'b0;
      bus.enable       = tbl[i].en;
      step();
      check($sformatf("wr%0d_port", i), bus.port_q, tbl[i].exp);
      bus.enable = 8'h00;
      prev = tbl[i].exp;
    end
    check("no_commit_busy", 64'(bus.busy), 64'h0);

    for (int i = 0; i < 7; i++) wr_port(i, 8'(8'h10 + i));
    check("load_port", bus.port_q, {8'h00, SNAP_A});

    push(SNAP_A, 8'h3C);
    wr_port(7, 8'h3C);
    check("hs_req0", 64'(bus.req), 64'h1);
    check("hs_busy0", 64'(bus.busy), 64'h1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("hs_req%0d", k), 64'(bus.req), 64'h1);
    end
    bus.ack = 1'b1;
    step();
    check("hs_req_drop", 64'(bus.req), 64'h0);
    check("hs_busy_wl", 64'(bus.busy), 64'h1);
    check("hs_done_early", 64'(bus.done), 64'h0);
    step();
    bus.ack = 1'b0;
    check("hs_wl_hold", 64'(bus.busy), 64'h1);
    step();
    check("hs_done", 64'(bus.done), 64'h1);
    check("hs_busy_fall", 64'(bus.busy), 64'h0);
    check("hs_cmd", 64'(bus.cmd_q), 64'h3C);
    check("hs_snap", 64'(bus.snap_q), 64'(SNAP_A));
    step();
    check("hs_done_1cyc", 64'(bus.done), 64'h0);

    push(SNAP_A, 8'h55);
    wr_port(7, 8'h55);
    wr_port(7, 8'h66);
    check("ovr_cmd", 64'(bus.cmd_q), 64'h55);
    check("ovr_status", 64'(bus.status), 64'h03);
    check("ovr_port7", 64'(bus.port_q[63:56]), 64'h66);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    step();
    check("ovr_done", 64'(bus.done), 64'h1);
    check("ovr_sticky", 64'(bus.status), 64'h02);
    step();

    push(SNAP_A, 8'h77);
    wr_port(7, 8'h77);
    check("ovr_clear", 64'(bus.status), 64'h01);
    dc = done_cnt;
    n  = 0;
    while (bus.req && n < 100) begin
      n++;
      step();
    end
    check("tmo_cycles", 64'(n), 64'd15);
    check("tmo_status", 64'(bus.status), 64'h04);
    check("tmo_no_done", 64'(done_cnt), 64'(dc));
    step();

    push(SNAP_A, 8'h81);
    wr_port(7, 8'h81);
    check("b2b_status", 64'(bus.status), 64'h01);
    push(SNAP_A, 8'h92);
    bus.ack          = 1'b1;
    bus.write_strobe = 1'b1;
    bus.out_port     = 8'h92;
    step();
    check("b2b_wl", 64'(bus.req), 64'h0);
    bus.write_strobe = 1'b0;
    bus.enable       = 8'h80;
    bus.ack          = 1'b0;
    step();
    bus.enable = 8'h00;
    check("b2b_done", 64'(bus.done), 64'h1);
    check("b2b_req", 64'(bus.req), 64'h1);
    check("b2b_cmd", 64'(bus.cmd_q), 64'h92);
    step();
    check("b2b_done_off", 64'(bus.done), 64'h0);
    check("b2b_req_hold", 64'(bus.req), 64'h1);

    #2;
    rst = 1'b0;
    #1;
    check("mrst_req", 64'(bus.req), 64'h0);
    check("mrst_busy", 64'(bus.busy), 64'h0);
    check("mrst_port", bus.port_q, 64'h0);
    step();
    rst = 1'b1;
    step();
    check("mrst_status", 64'(bus.status), 64'h00);
    check("mrst_cmd", 64'(bus.cmd_q), 64'h0);
    check("mrst_snap", 64'(bus.snap_q), 64'h0);

    bus.ack = 1'b1;
    step();
    step();
    check("idle_ack_busy", 64'(bus.busy), 64'h0);
    push(56'h0, 8'hC3);
    wr_port(7, 8'hC3);
    check("early_ack_req", 64'(bus.req), 64'h1);
    step();
    check("early_ack_wl", 64'(bus.req), 64'h0);
    check("early_ack_busy", 64'(bus.busy), 64'h1);
    bus.ack = 1'b0;
    step();
    check("early_ack_done", 64'(bus.done), 64'h1);
    step();
    step();
    check("done_total", 64'(done_cnt), 64'd4);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/banco_salida_rtc.md
Name: banco_salida_rtc

Overview:
- Output register bank plus commit engine sitting directly downstream of the PicoBlaze output-port decoder.
- Consumes the decoder's registered one-hot enable together with write_strobe and out_port.
- Stores eight 8-bit output ports.
- A write to the command port snapshots the data ports and hands them to the RTC bus controller over a four-phase req/ack handshake, with timeout supervision.

Parameters:
- DATA_W, 8, width of each port register and of out_port.
- CMD_IDX, 7, enable bit index treated as the command/commit port.
- TIMEOUT, 1023, max cycles in REQ waiting for ack before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  8  one-hot port select from the output decoder; lags port_id by one cycle.
- write_strobe  input  1  PicoBlaze write strobe, aligned with port_id (one cycle ahead of enable).
- out_port  input  DATA_W  PicoBlaze output data; held valid two cycles.
- ack  input  1  handshake acknowledge from the RTC bus controller.
- port_q  output  8*DATA_W  live contents of all eight port registers; port i occupies bits [8i+7:8i].
- snap_q  output  7*DATA_W  snapshot of ports 0..6 taken at commit.
- cmd_q  output  DATA_W  command byte captured at commit.
- req  output  1  handshake request.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse on handshake completion.
- status  output  8  {5'b0, timeout_flag, overrun_flag, busy}, returned to PicoBlaze as an input port.

Behaviour:
- Reset (rst low, asynchronous): all port registers, snap_q, cmd_q, the strobe delay register, flags and timeout counter clear to 0. State goes to IDLE. req, busy and done are 0 immediately and stay 0 while rst is low.
- Alignment: ws_d <= write_strobe every cycle. A write is accepted for bit i when ws_d and enable[i] are both high; out_port is sampled in that same cycle. Latency from strobe to port_q update is 2 cycles.
- More than one enable bit set: every selected register is written (no priority).
- Writing ports 0..6: always accepted, including while busy. These writes never alter snap_q.
- Writing CMD_IDX: port register 7 always updates. A commit starts only if the commit condition is met.
  - Commit condition: state == IDLE, or state == WAIT_LOW with ack == 0.
  - On commit: snap_q <= ports 0..6, taking the value from the current cycle's write when the same register is written simultaneously. cmd_q <= out_port; overrun_flag <= 0; timeout_flag <= 0; state -> REQ.
  - If the commit condition is false: the commit is dropped and overrun_flag <= 1 (sticky).
- FSM states: IDLE, REQ, WAIT_LOW.
  - IDLE: req = 0. Leaves only on commit.
  - REQ: req = 1 and the timeout counter increments each cycle.
    - ack == 1 -> WAIT_LOW, counter cleared.
    - Counter reaches TIMEOUT with ack == 0 -> IDLE, timeout_flag <= 1, no done pulse.
  - WAIT_LOW: req = 0.
    - ack == 0 -> IDLE with done = 1 for that one cycle.
    - If a commit arrives in that same cycle, done still pulses and the next state is REQ.
- ack high while in IDLE is ignored.
- ack already high on entry to REQ is accepted on the first REQ cycle.
- All outputs are registered. req is decoded from the registered state.

Decomposition:
- Shared package holds the state encoding (IDLE = 2'd0, REQ = 2'd1, WAIT_LOW = 2'd2), the CMD_IDX default, and status bit positions (BUSY = 0, OVERRUN = 1, TIMEOUT = 2).
- One natural sub-module: hs_timeout_cnt, a clearable saturating counter with a terminal-count flag, reusable by other bus handshakes.

Test Plan:
- Reset mid-handshake: drive rst low while in REQ -> req = 0 and port_q = 0 immediately; status = 8'h00 after release.
- Port write timing:
  - Stimulus: write_strobe with out_port = 8'hA5 at cycle t; enable = 8'b0000_0100 at t+1.
  - Required: port_q[23:16] = 8'hA5 from t+2; other ports unchanged.
- Commit + handshake:
  - Stimulus: load ports 0..6 with 8'h10..8'h16, write 8'h3C to port 7, ack asserted 3 cycles after req, deasserted 2 cycles later.
  - Required: snap_q = {8'h16..8'h10}, cmd_q = 8'h3C, req high exactly until ack is seen, one done pulse, busy falls the same cycle.
- Overrun: second port-7 write while in REQ -> cmd_q unchanged, status = 8'h03. Next accepted commit clears bit 1.
- Timeout:
  - Stimulus: TIMEOUT = 15, ack held low.
  - Required: req drops after 15 REQ cycles, no done pulse, status = 8'h04.
- Back-to-back: commit in the WAIT_LOW cycle with ack = 0 -> done pulses and req reasserts the next cycle with the new cmd_q.
